// File: rtl/vga_pkg.sv
// Shared display-pipeline types: timing defaults, pattern mode encodings,
// colour-bar table and the mode-handshake state encoding.
package vga_pkg;

    localparam int H_DISPLAY_DEF = 800;
    localparam int V_DISPLAY_DEF = 480;
    localparam int BOX_SIZE_DEF  = 32;

    typedef enum logic [1:0] {
        BARS     = 2'd0,
        CHECKER  = 2'd1,
        GRADIENT = 2'd2,
        BOX      = 2'd3
    } mode_e;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_PEND = 1'b1
    } hs_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Entry 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic rgb_t bar_rgb(input logic [2:0] idx);
        return rgb_t'(BAR_TABLE[idx]);
    endfunction

endpackage

// File: rtl/pixel_gen_if.sv
// Pattern-mode request channel: valid/ready handshake carrying a 2-bit mode.
interface pixel_gen_if;

    logic [1:0] mode_req;
    logic       mode_valid;
    logic       mode_ready;

    modport master (output mode_req, output mode_valid, input mode_ready);
    modport slave  (input mode_req, input mode_valid, output mode_ready);

endinterface

// File: rtl/box_mover.sv
// Bouncing-box position: one step per frame strobe on each axis, reflecting
// off the screen edges within the same frame.
module box_mover
    import vga_pkg::*;
#(
    parameter int HDISPLAY = H_DISPLAY_DEF,
    parameter int VDISPLAY = V_DISPLAY_DEF,
    parameter int BOX_SIZE = BOX_SIZE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_strobe,
    output logic [11:0] bx,
    output logic [11:0] by
);

    localparam logic [11:0] X_MAX = 12'(HDISPLAY - BOX_SIZE);
    localparam logic [11:0] Y_MAX = 12'(VDISPLAY - BOX_SIZE);

    logic dx_pos, dy_pos;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bx     <= '0;
            by     <= '0;
            dx_pos <= 1'b1;
            dy_pos <= 1'b1;
        end else if (frame_strobe) begin
            // At a wall the direction flips and the step is taken the other way now.
            if (dx_pos) begin
                if (bx >= X_MAX) begin
                    dx_pos <= 1'b0;
                    bx     <= bx - 12'd1;
                end else begin
                    bx <= bx + 12'd1;
                end
            end else begin
                if (bx == '0) begin
                    dx_pos <= 1'b1;
                    bx     <= bx + 12'd1;
                end else begin
                    bx <= bx - 12'd1;
                end
            end
            if (dy_pos) begin
                if (by >= Y_MAX) begin
                    dy_pos <= 1'b0;
                    by     <= by - 12'd1;
                end else begin
                    by <= by + 12'd1;
                end
            end else begin
                if (by == '0) begin
                    dy_pos <= 1'b1;
                    by     <= by + 12'd1;
                end else begin
                    by <= by - 12'd1;
                end
            end
        end
    end

endmodule

// File: rtl/pixel_gen.sv
// Test-pattern generator: two-stage pipeline from timing-generator inputs to
// RGB, with frame-synchronous pattern mode changes and a bouncing box.
module pixel_gen
    import vga_pkg::*;
#(
    parameter int HDISPLAY = H_DISPLAY_DEF,
    parameter int VDISPLAY = V_DISPLAY_DEF,
    parameter int BOX_SIZE = BOX_SIZE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] hpos,
    input  logic [11:0] vpos,
    pixel_gen_if.slave  mode_bus,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [15:0] frame_cnt
);

    localparam int BAR_W = HDISPLAY / 8;

    logic        strobe_cond, strobe_cond_q, frame_strobe;
    hs_state_e   hs_state, hs_next;
    logic        accept, apply;
    mode_e       mode, pend_mode;
    logic [11:0] bx, by;
    logic [1:0]  vld_pipe;
    logic        hs1, vs1;
    logic [11:0] h1, v1;
    logic [2:0]  bar_idx;
    logic        in_box;
    rgb_t        colour, rgb_q;

    // Edge-qualified so a stalled timing generator still yields a single strobe.
    assign strobe_cond  = (hpos == '0) && (vpos == 12'(VDISPLAY));
    assign frame_strobe = strobe_cond && !strobe_cond_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hs_state <= HS_IDLE;
        else        hs_state <= hs_next;
    end

    always_comb begin
        hs_next = hs_state;
        case (hs_state)
            HS_IDLE: if (mode_bus.mode_valid) hs_next = HS_PEND;
            HS_PEND: if (frame_strobe)        hs_next = HS_IDLE;
            default:                          hs_next = HS_IDLE;
        endcase
    end

    always_comb begin
        mode_bus.mode_ready = (hs_state == HS_IDLE);
        accept              = (hs_state == HS_IDLE) && mode_bus.mode_valid;
        apply               = (hs_state == HS_PEND) && frame_strobe;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_cond_q <= 1'b0;
            pend_mode     <= BARS;
            mode          <= BARS;
            frame_cnt     <= '0;
        end else begin
            strobe_cond_q <= strobe_cond;
            if (accept)       pend_mode <= mode_e'(mode_bus.mode_req);
            if (apply)        mode      <= pend_mode;
            if (frame_strobe) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    box_mover #(
        .HDISPLAY (HDISPLAY),
        .VDISPLAY (VDISPLAY),
        .BOX_SIZE (BOX_SIZE)
    ) u_box (
        .clk          (clk),
        .reset        (reset),
        .frame_strobe (frame_strobe),
        .bx           (bx),
        .by           (by)
    );

    // Bar index as a count of crossed thresholds, so no divider is built.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++)
            if (h1 >= 12'(k * BAR_W)) bar_idx = 3'(k);
    end

    assign in_box = ({1'b0, h1} >= {1'b0, bx}) && ({1'b0, h1} < ({1'b0, bx} + 13'(BOX_SIZE))) &&
                    ({1'b0, v1} >= {1'b0, by}) && ({1'b0, v1} < ({1'b0, by} + 13'(BOX_SIZE)));

    always_comb begin
        colour = '0;
        case (mode)
            BARS:     colour = bar_rgb(bar_idx);
            CHECKER:  colour = (h1[5] ^ v1[5]) ? 24'hFFFFFF : 24'h000000;
            GRADIENT: colour = {h1[9:2], v1[8:1], 8'h80};
            BOX:      colour = in_box ? 24'hFFFFFF : 24'h000000;
            default:  colour = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe  <= '0;
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            h1        <= '0;
            v1        <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            rgb_q     <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[0], de_in};
            hs1       <= hsync_in;
            vs1       <= vsync_in;
            h1        <= hpos;
            v1        <= vpos;
            hsync_out <= hs1;
            vsync_out <= vs1;
            rgb_q     <= vld_pipe[0] ? colour : '0;
        end
    end

    assign de_out = vld_pipe[1];
    assign red    = rgb_q.r;
    assign green  = rgb_q.g;
    assign blue   = rgb_q.b;

endmodule

// File: tb/tb_pixel_gen.sv
// Bench for pixel_gen: directed vectors, literal spot checks and a per-cycle
// compare against an arithmetic model of the pattern/mode/box behaviour.
module tb_pixel_gen;

    localparam int HD = 800;
    localparam int VD = 480;
    localparam int BS = 32;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } exp_t;

    localparam exp_t RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'h0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        de_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [11:0] hpos = '0, vpos = '0;
    logic        de_out, hsync_out, vsync_out;
    logic [7:0]  red, green, blue;
    logic [15:0] frame_cnt;

    pixel_gen_if mbus ();

    pixel_gen #(.HDISPLAY(HD), .VDISPLAY(VD), .BOX_SIZE(BS)) dut (
        .clk       (clk),
        .reset     (reset),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .hpos      (hpos),
        .vpos      (vpos),
        .mode_bus  (mbus.slave),
        .de_out    (de_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    logic chk_en = 1'b0;

    // Model state
    int          m_mode = 0, m_pmode = 0, m_n = 0;
    logic        m_pend = 1'b0;
    logic [15:0] m_fcnt = '0;
    exp_t        p1 = RST, p_out = RST;

    // Box position after n strobes: triangle wave between 0 and lim.
    function automatic int bounce(input int n, input int lim);
        int p;
        p = n % (2 * lim);
        return (p <= lim) ? p : 2 * lim - p;
    endfunction

    function automatic logic [23:0] model_colour(input int h, input int v, input int md, input int n);
        int bxm, bym;
        bxm = bounce(n, HD - BS);
        bym = bounce(n, VD - BS);
        case (md)
            0: case (h / (HD / 8))
                   0: return 24'hFFFFFF;
                   1: return 24'hFFFF00;
                   2: return 24'h00FFFF;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'hFF0000;
                   6: return 24'h0000FF;
                   default: return 24'h000000;
               endcase
            1: return ((((h / 32) % 2) ^ ((v / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
            2: return {8'((h / 4) % 256), 8'((v / 2) % 256), 8'h80};
            default: return (h >= bxm && h < bxm + BS && v >= bym && v < bym + BS) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0; m_pmode = 0; m_pend = 1'b0; m_n = 0; m_fcnt = '0;
            p1 = RST; p_out = RST;
        end else begin
            logic strobe, acc;
            exp_t e;
            strobe = (hpos == 12'd0) && (vpos == 12'(VD));
            acc    = mbus.mode_valid && !m_pend;
            if (strobe && m_pend) begin m_mode = m_pmode; m_pend = 1'b0; end
            if (acc) begin m_pend = 1'b1; m_pmode = int'(mbus.mode_req); end
            if (strobe) begin m_n++; m_fcnt = m_fcnt + 16'd1; end
            e.de  = de_in;
            e.hs  = hsync_in;
            e.vs  = vsync_in;
            e.rgb = de_in ? model_colour(int'(hpos), int'(vpos), m_mode, m_n) : 24'h0;
            p_out = p1;
            p1    = e;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_t        e;
            logic [15:0] ef;
            logic        er;
            if (!reset) begin e = RST; ef = '0; er = 1'b1; end
            else begin e = p_out; ef = m_fcnt; er = !m_pend; end
            vectors++;
            if ({de_out, hsync_out, vsync_out, red, green, blue} !== e || frame_cnt !== ef ||
                mbus.mode_ready !== er) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t: got de/hs/vs=%b%b%b rgb=%h%h%h fcnt=%0d rdy=%b, want %b%b%b rgb=%h fcnt=%0d rdy=%b",
                         $time, de_out, hsync_out, vsync_out, red, green, blue, frame_cnt, mbus.mode_ready,
                         e.de, e.hs, e.vs, e.rgb, ef, er);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic de,
                         input logic hs = 1'b1, input logic vs = 1'b1);
        @(posedge clk);
        #2;
        hpos = 12'(h); vpos = 12'(v); de_in = de; hsync_in = hs; vsync_in = vs;
    endtask

    // Present one pixel, then check the colour two edges later.
    task automatic probe(input int h, input int v, input logic [23:0] exp, input string name);
        drive(h, v, 1'b1);
        drive(0, 0, 1'b0);
        @(posedge clk);
        #3;
        check(name, {de_out, red, green, blue}, {1'b1, exp});
    endtask

    task automatic strobe();
        drive(0, VD, 1'b0);
        drive(0, 0, 1'b0);
    endtask

    task automatic req_mode(input logic [1:0] m, input logic on_strobe);
        @(posedge clk);
        #2;
        mbus.mode_req = m; mbus.mode_valid = 1'b1;
        hpos = '0; vpos = on_strobe ? 12'(VD) : 12'd0; de_in = 1'b0;
        @(posedge clk);
        #1;
        check("ready_drops", 32'(mbus.mode_ready), 32'd0);
        #1;
        mbus.mode_valid = 1'b0; hpos = '0; vpos = '0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {de_out, hsync_out, vsync_out, red, green, blue, frame_cnt, mbus.mode_ready},
              {1'b0, 1'b1, 1'b1, 24'h0});
    endtask

    initial begin
        mbus.mode_req = 2'd0; mbus.mode_valid = 1'b0;
        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_de_out", 32'(de_out), 32'd0);
        check("rst_syncs", {hsync_out, vsync_out}, 32'd3);
        check("rst_rgb", {red, green, blue}, 32'd0);
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        check("rst_ready", 32'(mbus.mode_ready), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;

        // Colour bars
        probe(0, 0, 24'hFFFFFF, "bars_white");
        probe(700, 0, 24'h000000, "bars_black");
        probe(99, 3, 24'hFFFFFF, "bars_edge99");
        probe(100, 3, 24'hFFFF00, "bars_edge100");
        probe(450, 9, 24'hFF00FF, "bars_magenta");
        probe(805, 9, 24'h000000, "bars_beyond");

        // hsync low for 23 cycles, expected 2 cycles later
        for (int i = 0; i < 27; i++) begin
            drive(i, 10, 1'b1, (i < 23) ? 1'b0 : 1'b1, (i < 5) ? 1'b0 : 1'b1);
            @(negedge clk);
            check("hsync_delay", 32'(hsync_out), (i >= 2 && i < 25) ? 32'd0 : 32'd1);
        end
        drive(0, 0, 1'b0);

        // Mid-frame request for checkerboard
        req_mode(2'd1, 1'b0);
        probe(0, 5, 24'hFFFFFF, "still_bars");
        check("ready_held", 32'(mbus.mode_ready), 32'd0);
        strobe();
        #1 check("ready_back", 32'(mbus.mode_ready), 32'd1);
        probe(32, 0, 24'hFFFFFF, "checker_white");
        probe(0, 5, 24'h000000, "checker_black");
        probe(33, 40, 24'h000000, "checker_diag");

        // Request on the strobe cycle waits a full frame
        req_mode(2'd2, 1'b1);
        probe(0, 5, 24'h000000, "req_on_strobe_defer");
        strobe();
        probe(40, 6, 24'h0A0380, "gradient");
        probe(1023, 511, 24'hFFFF80, "gradient_beyond");
        check("fcnt_3", 32'(frame_cnt), 32'd3);

        // Async reset mid-line
        drive(10, 10, 1'b1);
        drive(11, 10, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_de", 32'(de_out), 32'd0);
        check("midrst_syncs", {hsync_out, vsync_out}, 32'd3);
        check("midrst_rgb", {red, green, blue}, 32'd0);
        check("midrst_fcnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        probe(0, 0, 24'hFFFFFF, "post_rst_bars");

        // Bouncing box from reset
        req_mode(2'd3, 1'b0);
        for (int n = 1; n <= 800; n++) begin
            strobe();
            if (n == 1) begin
                probe(1, 1, 24'hFFFFFF, "box_n1_in");
                probe(0, 1, 24'h000000, "box_n1_left");
            end
            if (n == 448) begin
                probe(448, 448, 24'hFFFFFF, "box_ymax_in");
                probe(448, 447, 24'h000000, "box_ymax_above");
            end
            if (n == 449) begin
                probe(449, 478, 24'hFFFFFF, "box_yback_in");
                probe(449, 479, 24'h000000, "box_yback_below");
            end
            if (n == 768) begin
                probe(768, 128, 24'hFFFFFF, "box_xmax_in");
                probe(767, 128, 24'h000000, "box_xmax_left");
                probe(799, 159, 24'hFFFFFF, "box_xmax_corner");
            end
            if (n == 800) begin
                probe(736, 96, 24'hFFFFFF, "box_800_in");
                probe(735, 96, 24'h000000, "box_800_left");
                probe(768, 96, 24'h000000, "box_800_right");
            end
        end
        check("fcnt_800", 32'(frame_cnt), 32'd800);

        repeat (2) @(posedge clk);
        #4;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
